div_hilo_sequencer: RTL
=======================

Name: div_hilo_sequencer

Overview:
Multi-cycle sequencer for the iterative DIVU unit and the HiLo register pair. It sits beside the EX stage. It accepts DIVU from the EX-stage function code, drives the divider's load and shift-step strobes for DIV_CYCLES cycles, then issues a single HiLo write enable. It stalls the pipeline on any MFHI, MFLO or DIVU that arrives while a divide is in flight.

Parameters:
DIV_CYCLES, 32, number of divider iteration cycles (one quotient bit per cycle)
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > DIV_CYCLES
F_DIVU, 6'b011011, funct code for DIVU
F_MFHI, 6'b010000, funct code for MFHI
F_MFLO, 6'b010010, funct code for MFLO

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
valid  in  1  EX-stage slot holds a real R-type instruction (not a bubble)
funct  in  6  function field of the EX-stage instruction
div_zero  in  1  divisor operand == 0; sampled only in the accept cycle
div_load  out  1  combinational; latch dividend/divisor into divider this cycle
div_step  out  1  registered-state decode; perform one divider iteration
step_count  out  CNT_W  current iteration index
hilo_we  out  1  write divider remainder/quotient into HiLo at this edge
dz_flag  out  1  one-cycle pulse: divide-by-zero divide completed
busy  out  1  divide in flight (state != IDLE)
stall  out  1  combinational; hold IF/ID/EX and bubble MEM

Behaviour:
- Reset: state=IDLE, step_count=0. All outputs 0 while reset is high and in the cycle after. Reset mid-divide aborts silently; no hilo_we or dz_flag for the aborted op.
- States: IDLE, RUN, WRITE.
- accept = (state==IDLE) & valid & (funct==F_DIVU). div_load = accept. stall=0 in the accept cycle, so the DIVU proceeds.
- IDLE -> RUN on accept with div_zero=0. step_count <= 0.
- IDLE -> WRITE on accept with div_zero=1. Iteration is skipped.
- RUN: div_step=1 every cycle. step_count increments by 1 each cycle. When step_count==DIV_CYCLES-1, next state is WRITE and step_count <= 0.
- WRITE: hilo_we=1 for exactly one cycle. dz_flag=1 in this cycle iff the op was accepted with div_zero=1 (a registered bit captured at accept). Next state is IDLE.
- Timing for accept at cycle T (div_zero=0):
  - div_step is high in T+1..T+DIV_CYCLES, with step_count 0..DIV_CYCLES-1.
  - hilo_we is high in T+DIV_CYCLES+1.
  - busy is high in T+1..T+DIV_CYCLES+1.
  - IDLE is reached in T+DIV_CYCLES+2.
- Timing for accept at T with div_zero=1: hilo_we, dz_flag and busy are high in T+1 only.
- stall = busy & valid & (funct ∈ {F_DIVU, F_MFHI, F_MFLO}).
  - Stall holds through the WRITE cycle. MFHI/MFLO are released in the first IDLE cycle, when they read the updated HiLo.
  - A stalled DIVU becomes an accept in that first IDLE cycle, so back-to-back divides carry no extra bubble.
- Other funct values, or valid=0, never stall and never change state.
- step_count reads 0 in IDLE and WRITE.
- div_step, hilo_we and div_load are mutually exclusive in every cycle.
- div_zero is ignored outside the accept cycle.
- Reset has priority over accept in the same cycle.

Test Plan:
1. Reset, then valid=1 funct=DIVU at cycle T with div_zero=0 -> div_load=1 at T; div_step=1 T+1..T+32 with step_count 0..31; hilo_we=1 only at T+33; busy T+1..T+33; dz_flag never high.
2. DIVU at T, then MFLO held in EX from T+5 -> stall=1 T+5..T+33; stall=0 at T+34 (IDLE); no new state change from MFLO.
3. DIVU at T, second DIVU held from T+1 -> stall T+1..T+33; second accept at T+34 (div_load=1); its hilo_we at T+67.
4. DIVU with div_zero=1 at T -> hilo_we=1, dz_flag=1, busy=1 at T+1 only; IDLE at T+2; div_step never high.
5. DIVU at T, reset asserted at T+10 for one cycle -> all outputs 0 from T+11; no hilo_we at T+33; new DIVU at T+12 accepted normally.
6. valid=0 with funct=DIVU, and valid=1 with funct=ADD (6'b100000) while busy -> no accept, stall=0, divide timing from scenario 1 unchanged.

Source files
------------

// File: rtl/div_hilo_sequencer.sv
// Multi-cycle sequencer for the iterative DIVU unit and HiLo register pair.
// Drives divider load/step strobes, a single HiLo write, and EX-stage stalls.
module div_hilo_sequencer #(
    parameter int          DIV_CYCLES = 32,
    parameter int          CNT_W      = 6,
    parameter logic [5:0]  F_DIVU     = 6'b011011,
    parameter logic [5:0]  F_MFHI     = 6'b010000,
    parameter logic [5:0]  F_MFLO     = 6'b010010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic             div_zero,
    output logic             div_load,
    output logic             div_step,
    output logic [CNT_W-1:0] step_count,
    output logic             hilo_we,
    output logic             dz_flag,
    output logic             busy,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_dz;
    logic             w_dz_next;
    logic             w_accept;
    logic             w_hazard_op;

    assign w_hazard_op = (funct == F_DIVU) || (funct == F_MFHI) || (funct == F_MFLO);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_dz_next  = r_dz;
        // Reset outranks accept, and every output is forced low while it is high.
        w_accept   = !reset && (r_state == S_IDLE) && valid && (funct == F_DIVU);

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dz_next  = div_zero;
                    w_cnt_next = '0;
                    w_next     = div_zero ? S_WRITE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_next = '0;
                    w_next     = S_WRITE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase

        div_load   = w_accept;
        div_step   = !reset && (r_state == S_RUN);
        step_count = reset ? '0 : r_cnt;
        hilo_we    = !reset && (r_state == S_WRITE);
        dz_flag    = !reset && (r_state == S_WRITE) && r_dz;
        busy       = !reset && (r_state != S_IDLE);
        // Held through WRITE so MFHI/MFLO read the updated HiLo in the first IDLE cycle.
        stall      = busy && valid && w_hazard_op;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_dz    <= w_dz_next;
        end
    end

endmodule
